// File: rtl/branch_pkg.sv
// Types and constants shared by the branch predictor and its resolution unit.
// Both sides agree on the in-flight entry layout and the training packet width.
package branch_pkg;

    localparam int BP_DBITS    = 32;
    localparam int BP_GHR_BITS = 8;
    localparam int BP_DEPTH    = 4;
    localparam int BP_INSTSIZE = 4;

    typedef struct packed {
        logic [BP_DBITS-1:0]    pc;
        logic [BP_DBITS-1:0]    pred_pc;
        logic [BP_GHR_BITS-1:0] bhr;
    } bp_entry_t;

    // Training packet: {valid, taken, pc, target, bhr}
    localparam int BP_UPD_W = 2 + 2 * BP_DBITS + BP_GHR_BITS;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions. The head is read combinationally
// so the resolver can compare it in the same cycle the instruction leaves AGEX.
module bp_inflight_fifo
    import branch_pkg::*;
#(
    parameter int WIDTH = $bits(bp_entry_t),
    parameter int DEPTH = BP_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks each FE prediction against the AGEX outcome, producing predictor
// training packets, a registered redirect flush and saturating statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DBITS    = BP_DBITS,
    parameter int GHR_BITS = BP_GHR_BITS,
    parameter int DEPTH    = BP_DEPTH,
    parameter int INSTSIZE = BP_INSTSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fe_valid,
    input  logic [DBITS-1:0]    fe_pc,
    input  logic [DBITS-1:0]    fe_pred_pc,
    input  logic [GHR_BITS-1:0] fe_bhr,
    output logic                fe_stall,
    input  logic                agex_valid,
    input  logic [DBITS-1:0]    agex_pc,
    input  logic                agex_is_br,
    input  logic                agex_taken,
    input  logic [DBITS-1:0]    agex_target,
    output logic                upd_valid,
    output logic                upd_taken,
    output logic [DBITS-1:0]    upd_pc,
    output logic [DBITS-1:0]    upd_target,
    output logic [GHR_BITS-1:0] upd_bhr,
    output logic                flush,
    output logic [DBITS-1:0]    flush_pc,
    output logic [31:0]         br_count,
    output logic [31:0]         mp_count,
    output logic                proto_err
);
    typedef struct packed {
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pred_pc;
        logic [GHR_BITS-1:0] bhr;
    } entry_t;

    entry_t        wr_entry;
    entry_t        head;
    logic          q_full;
    logic          q_empty;
    logic          push_ok;
    logic          pop_ok;
    logic          mispredict;
    logic [DBITS-1:0] actual_next;

    logic                upd_valid_reg;
    logic                upd_taken_reg;
    logic [DBITS-1:0]    upd_pc_reg;
    logic [DBITS-1:0]    upd_target_reg;
    logic [GHR_BITS-1:0] upd_bhr_reg;
    logic                flush_reg;
    logic [DBITS-1:0]    flush_pc_reg;
    logic [31:0]         br_count_reg;
    logic [31:0]         mp_count_reg;
    logic                proto_err_reg;

    assign wr_entry = '{pc: fe_pc, pred_pc: fe_pred_pc, bhr: fe_bhr};

    // The flush cycle discards the whole queue, so nothing else may move then.
    // A push into a full queue is accepted when a pop frees the head slot.
    assign pop_ok  = agex_valid && !flush_reg && !q_empty;
    assign push_ok = fe_valid && !flush_reg && (!q_full || pop_ok);

    bp_inflight_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush_reg),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (wr_entry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign fe_stall    = q_full;
    assign actual_next = (agex_is_br && agex_taken) ? agex_target
                                                    : agex_pc + DBITS'(INSTSIZE);
    assign mispredict  = (actual_next != head.pred_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_reg  <= 1'b0;
            upd_taken_reg  <= 1'b0;
            upd_pc_reg     <= '0;
            upd_target_reg <= '0;
            upd_bhr_reg    <= '0;
            flush_reg      <= 1'b0;
            flush_pc_reg   <= '0;
            br_count_reg   <= '0;
            mp_count_reg   <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            upd_valid_reg <= pop_ok && agex_is_br;
            flush_reg     <= pop_ok && mispredict;
            if (pop_ok && agex_is_br) begin
                upd_taken_reg  <= agex_taken;
                upd_pc_reg     <= agex_pc;
                upd_target_reg <= agex_target;
                upd_bhr_reg    <= head.bhr;
            end
            if (pop_ok && mispredict) begin
                flush_pc_reg <= actual_next;
            end
            if (pop_ok && agex_is_br && br_count_reg != 32'hFFFF_FFFF) begin
                br_count_reg <= br_count_reg + 32'd1;
            end
            if (pop_ok && mispredict && mp_count_reg != 32'hFFFF_FFFF) begin
                mp_count_reg <= mp_count_reg + 32'd1;
            end
            // A stray pop or a head that is not the retiring instruction means
            // FE and AGEX have lost lockstep; latch it until reset.
            if (agex_valid && !flush_reg && (q_empty || head.pc != agex_pc)) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign upd_valid  = upd_valid_reg;
    assign upd_taken  = upd_taken_reg;
    assign upd_pc     = upd_pc_reg;
    assign upd_target = upd_target_reg;
    assign upd_bhr    = upd_bhr_reg;
    assign flush      = flush_reg;
    assign flush_pc   = flush_pc_reg;
    assign br_count   = br_count_reg;
    assign mp_count   = mp_count_reg;
    assign proto_err  = proto_err_reg;

endmodule
